mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Sequential multiply/divide unit for the MIPS datapath; the multi-cycle companion to the combinational add/sub/slt arithmetic unit.
- Executes MULT, MULTU, DIV and DIVU on N-bit operands, one radix-2 iteration per cycle.
- Writes a 2N-bit result into HI/LO registers.
- Uses a start/busy/done handshake so the pipeline can stall on busy.

Parameters:
- N, 32, operand width and HI/LO width (N >= 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- A  input  N  operand A / dividend
- B  input  N  operand B / divisor
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle completion pulse
- HI  output  N  MULT: upper product half; DIV: remainder
- LO  output  N  MULT: lower product half; DIV: quotient
- div_by_zero  output  1  set with done when a DIV/DIVU had B=0; cleared on next accepted start

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (async, any state, including mid-operation): state IDLE, busy=0, done=0, HI=0, LO=0, div_by_zero=0, iteration counter=0, internal work registers=0. Any in-flight operation is abandoned.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge k: latch op, the operand signs, and |A|, |B|.
  - Magnitudes are taken only for signed ops; unsigned ops use raw values.
  - counter=N, busy=1, div_by_zero=0, then go to RUN.
  - Exception: DIV/DIVU with B=0 goes directly to FINISH with the zero-divide flag set.
- RUN: one iteration per edge; counter decrements; after N iterations (edge k+N) go to FINISH.
  - Multiply: shift-add on a 2N-bit product register {P_hi, P_lo}.
    - If P_lo[0]=1, add multiplicand to P_hi with an N+1-bit carry.
    - Then shift the whole register right by 1.
  - Divide: restoring division on a {R, Q} register.
    - Shift left by 1.
    - Trial-subtract divisor from R (N+1 bits).
    - If non-negative: keep the difference and set Q[0]=1; else restore and set Q[0]=0.
- FINISH (one cycle; edge k+N+1):
  - Apply sign correction and write HI/LO.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Sign rules:
  - MULT: product negated (2N-bit two's complement) iff sign(A) xor sign(B).
  - DIV: quotient negated iff sign(A) xor sign(B); remainder takes the sign of A.
- Divide overflow: DIV of -2^(N-1) by -1 gives LO=2^(N-1) (wraps), HI=0. No flag.
- Divide by zero:
  - Result: HI=A, LO=all ones, div_by_zero=1.
  - Timing: done asserted after edge k+1, busy high for one cycle.
- Latency: normal ops raise done after edge k+N+1 and hold busy for N+1 cycles.
- HI/LO/div_by_zero hold their values until the next completion or reset.
- start while busy is ignored; operands may change freely after acceptance.
- start in the same cycle done is high is accepted, since the FSM is already in IDLE that cycle.
- done never asserts without a prior accepted start.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, RUN, FINISH
  - counter width: clog2(N+1)
- One natural sub-module: mdu_step, a combinational single-iteration datapath.
  - Parameter N.
  - Inputs: mode, current work register, operand.
  - Outputs: next work register.
  - mult_div_unit owns the FSM, counter, sign handling and HI/LO registers.

Test Plan (N=32):
- MULTU A=59, B=77, start at edge k -> busy 33 cycles; done after edge k+33; HI=0, LO=4543.
- MULT A=0xFFFFFDF0 (-528), B=456 -> HI=0xFFFFFFFF, LO=0xFFFC5380 (-240768).
- DIVU A=528, B=456 -> LO=1, HI=72.
- DIV A=0xFFFFFDD8 (-552), B=105 -> LO=0xFFFFFFFB (-5), HI=0xFFFFFFE5 (-27).
- DIV A=105, B=0 -> done after edge k+1; HI=105, LO=0xFFFFFFFF, div_by_zero=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
- Handshake:
  - Pulse start with new operands at cycle 10 of a running MULTU -> ignored; result still matches the first operation.
  - Drive rst_n=0 at cycle 15 of a run -> busy, done, HI, LO clear immediately without a clock edge.
  - After rst_n is released, a new MULTU 3x4 -> LO=12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the opcode and FSM encodings and the iteration counter width helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_e;

  // Counter must be able to hold the value N itself.
  function automatic int mdu_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: shift-add on {P_hi, P_lo}. Divide: restoring step on {R, Q}.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           i_div,
  input  logic [2*N-1:0] i_work,
  input  logic [N-1:0]   i_operand,
  output logic [2*N-1:0] o_work
);

  logic [N:0] w_sum;
  logic [N:0] w_rem_ext;
  logic [N:0] w_diff;

  // Single-iteration next work register for both modes
  always_comb begin
    w_sum     = {1'b0, i_work[2*N-1:N]} +
                (i_work[0] ? {1'b0, i_operand} : {(N+1){1'b0}});
    // Partial remainder after the left shift, carried in N+1 bits
    w_rem_ext = i_work[2*N-1:N-1];
    w_diff    = w_rem_ext - {1'b0, i_operand};
    if (i_div) begin
      if (w_diff[N]) begin
        o_work = {w_rem_ext[N-1:0], i_work[N-2:0], 1'b0};
      end else begin
        o_work = {w_diff[N-1:0], i_work[N-2:0], 1'b1};
      end
    end else begin
      o_work = {w_sum, i_work[N-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit with start/busy/done handshake.
// Works on magnitudes, one iteration per cycle, and sign-corrects into HI/LO on finish.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO,
  output logic         div_by_zero
);

  localparam int CW = mdu_cnt_w(N);
  localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

  state_e         r_state;
  state_e         w_next_state;
  op_e            r_op;
  logic           r_sign_a;
  logic           r_sign_b;
  logic           r_dz_pend;
  logic [2*N-1:0] r_work;
  logic [N-1:0]   r_opnd;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;
  logic [N-1:0]   r_hi;
  logic [N-1:0]   r_lo;

  logic           w_accept;
  logic           w_iterate;
  logic           w_finish;
  logic           w_signed;
  logic           w_b_zero;
  logic           w_div_req;
  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic           w_div_mode;
  logic [2*N-1:0] w_step_work;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quot;
  logic [N-1:0]   w_rem;
  logic [N-1:0]   w_res_hi;
  logic [N-1:0]   w_res_lo;

  // Operand decode at acceptance: magnitudes only for signed ops
  always_comb begin
    w_signed  = (op == OP_MULT) || (op == OP_DIV);
    w_div_req = (op == OP_DIV) || (op == OP_DIVU);
    w_b_zero  = (B == {N{1'b0}});
    w_mag_a   = (w_signed && A[N-1]) ? (~A + ONE_N) : A;
    w_mag_b   = (w_signed && B[N-1]) ? (~B + ONE_N) : B;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_iterate    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_div_req && w_b_zero) begin
            w_next_state = FINISH;
          end else begin
            w_next_state = RUN;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        w_iterate = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next_state = FINISH;
        end else begin
          w_next_state = RUN;
        end
      end
      FINISH: begin
        w_finish     = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_div_mode = (r_op == OP_DIV) || (r_op == OP_DIVU);

  mdu_step #(
    .N(N)
  ) u_step (
    .i_div    (w_div_mode),
    .i_work   (r_work),
    .i_operand(r_opnd),
    .o_work   (w_step_work)
  );

  // Sign correction of the finished magnitude result
  always_comb begin
    w_prod = (r_sign_a ^ r_sign_b) ? (~r_work + ONE_2N) : r_work;
    w_quot = (r_sign_a ^ r_sign_b) ? (~r_work[N-1:0] + ONE_N) : r_work[N-1:0];
    w_rem  = r_sign_a ? (~r_work[2*N-1:N] + ONE_N) : r_work[2*N-1:N];
    if (r_dz_pend) begin
      // Raw dividend was parked in the low half for the zero-divide result
      w_res_hi = r_work[N-1:0];
      w_res_lo = {N{1'b1}};
    end else if (w_div_mode) begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end else begin
      w_res_hi = w_prod[2*N-1:N];
      w_res_lo = w_prod[N-1:0];
    end
  end

  // Work registers, counter, handshake and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_MULT;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_dz_pend <= 1'b0;
      r_work    <= {(2*N){1'b0}};
      r_opnd    <= {N{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= {N{1'b0}};
      r_lo      <= {N{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op      <= op_e'(op);
        r_sign_a  <= w_signed & A[N-1];
        r_sign_b  <= w_signed & B[N-1];
        r_dz_pend <= w_div_req & w_b_zero;
        r_work    <= {{N{1'b0}}, ((w_div_req && w_b_zero) ? A : w_mag_a)};
        r_opnd    <= w_mag_b;
        r_cnt     <= CW'(N);
        r_busy    <= 1'b1;
        r_dbz     <= 1'b0;
      end else if (w_iterate) begin
        r_work <= w_step_work;
        r_cnt  <= r_cnt - CW'(1);
      end else if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_dbz  <= r_dz_pend;
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
